// File: rtl/miter_sweep_checker.sv
// miter_sweep_checker: exhaustive equivalence sweep over two combinational
// circuits. Drives every input vector in order, holds it for SETTLE cycles,
// compares the responses and stops at the first mismatch (SAT) or reports
// equivalence (UNSAT) after the all-ones vector.
module miter_sweep_checker #(
    parameter int unsigned N_IN   = 2,
    parameter int unsigned N_OUT  = 1,
    parameter int unsigned SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [N_OUT-1:0] resp_a,
    input  logic [N_OUT-1:0] resp_b,
    output logic [N_IN-1:0]  stim,
    output logic             busy,
    output logic             done,
    output logic             sat,
    output logic [N_IN-1:0]  cex,
    output logic [N_OUT-1:0] diff,
    output logic [N_IN:0]    vec_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_CMP,
        S_DONE
    } state_e;

    localparam logic [7:0]    SETTLE_W = 8'(SETTLE);
    localparam logic [7:0]    WCNT_ONE = 8'd1;
    localparam logic [N_IN-1:0] STIM_ONE = (N_IN)'(1);
    localparam logic [N_IN:0]   CNT_ONE  = (N_IN + 1)'(1);

    state_e             state_q, state_d;
    logic [7:0]         wcnt_q, wcnt_d;
    logic [N_IN-1:0]    stim_q, stim_d;
    logic [N_IN-1:0]    cex_q, cex_d;
    logic [N_OUT-1:0]   diff_q, diff_d;
    logic [N_IN:0]      vec_cnt_q, vec_cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               sat_q, sat_d;

    // State and result registers; async reset clears every output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            wcnt_q    <= '0;
            stim_q    <= '0;
            cex_q     <= '0;
            diff_q    <= '0;
            vec_cnt_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sat_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            stim_q    <= stim_d;
            cex_q     <= cex_d;
            diff_q    <= diff_d;
            vec_cnt_q <= vec_cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            sat_q     <= sat_d;
        end
    end

    // Sweep sequencing: abort has priority, everything else holds by default.
    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        stim_d    = stim_q;
        cex_d     = cex_q;
        diff_d    = diff_q;
        vec_cnt_d = vec_cnt_q;
        busy_d    = busy_q;
        done_d    = done_q;
        sat_d     = sat_q;

        if (abort) begin
            state_d   = S_IDLE;
            wcnt_d    = '0;
            stim_d    = '0;
            cex_d     = '0;
            diff_d    = '0;
            vec_cnt_d = '0;
            busy_d    = 1'b0;
            done_d    = 1'b0;
            sat_d     = 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_d   = S_WAIT;
                        wcnt_d    = SETTLE_W;
                        stim_d    = '0;
                        cex_d     = '0;
                        diff_d    = '0;
                        vec_cnt_d = '0;
                        busy_d    = 1'b1;
                        done_d    = 1'b0;
                        sat_d     = 1'b0;
                    end
                end
                S_WAIT: begin
                    if (wcnt_q != '0) begin
                        wcnt_d = wcnt_q - WCNT_ONE;
                    end else begin
                        state_d = S_CMP;
                    end
                end
                S_CMP: begin
                    vec_cnt_d = vec_cnt_q + CNT_ONE;
                    if (resp_a != resp_b) begin
                        sat_d   = 1'b1;
                        cex_d   = stim_q;
                        diff_d  = resp_a ^ resp_b;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else if (stim_q == '1) begin
                        sat_d   = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        stim_d  = stim_q + STIM_ONE;
                        wcnt_d  = SETTLE_W;
                        state_d = S_WAIT;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign stim    = stim_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign sat     = sat_q;
    assign cex     = cex_q;
    assign diff    = diff_q;
    assign vec_cnt = vec_cnt_q;

endmodule

// File: tb/tb_miter_sweep_checker.sv
// Bench for miter_sweep_checker: two instances (2-in/1-out/SETTLE=1 and
// 3-in/4-out/SETTLE=0) driven by truth tables; results are predicted by
// scanning the tables for the first differing vector.
module tb_miter_sweep_checker;

    logic clk;
    logic rst;
    logic start0, abort0, start1, abort1;

    logic [3:0] tbl_a [8];
    logic [3:0] tbl_b [8];

    logic [1:0] stim0, cex0;
    logic       busy0, done0, sat0;
    logic [0:0] ra0, rb0, diff0;
    logic [2:0] cnt0;

    logic [2:0] stim1, cex1;
    logic       busy1, done1, sat1;
    logic [3:0] ra1, rb1, diff1;
    logic [3:0] cnt1;

    int n_checks;
    int n_errors;
    int sel;

    logic [3:0] v_stim, v_cex, v_diff, v_cnt;
    logic       v_busy, v_done, v_sat;

    assign ra0 = tbl_a[{1'b0, stim0}][0];
    assign rb0 = tbl_b[{1'b0, stim0}][0];
    assign ra1 = tbl_a[stim1];
    assign rb1 = tbl_b[stim1];

    miter_sweep_checker #(.N_IN(2), .N_OUT(1), .SETTLE(1)) u0 (
        .clk(clk), .rst(rst), .start(start0), .abort(abort0),
        .resp_a(ra0), .resp_b(rb0), .stim(stim0), .busy(busy0),
        .done(done0), .sat(sat0), .cex(cex0), .diff(diff0), .vec_cnt(cnt0)
    );

    miter_sweep_checker #(.N_IN(3), .N_OUT(4), .SETTLE(0)) u1 (
        .clk(clk), .rst(rst), .start(start1), .abort(abort1),
        .resp_a(ra1), .resp_b(rb1), .stim(stim1), .busy(busy1),
        .done(done1), .sat(sat1), .cex(cex1), .diff(diff1), .vec_cnt(cnt1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // View of whichever instance is currently under test.
    always_comb begin
        if (sel == 0) begin
            v_stim = {2'b00, stim0};
            v_cex  = {2'b00, cex0};
            v_diff = {3'b000, diff0};
            v_cnt  = {1'b0, cnt0};
            v_busy = busy0;
            v_done = done0;
            v_sat  = sat0;
        end else begin
            v_stim = {1'b0, stim1};
            v_cex  = {1'b0, cex1};
            v_diff = diff1;
            v_cnt  = cnt1;
            v_busy = busy1;
            v_done = done1;
            v_sat  = sat1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (sel=%0d t=%0t)", tag, obs, exp, sel, $time);
        end
    endtask

    // First differing vector decides everything; no difference means UNSAT.
    task automatic model(input int s, output bit sat_e, output int cex_e,
                         output logic [3:0] diff_e, output int cnt_e);
        logic [3:0] mask;
        int n;
        mask   = (s != 0) ? 4'hF : 4'h1;
        n      = (s != 0) ? 8 : 4;
        sat_e  = 1'b0;
        cex_e  = 0;
        diff_e = '0;
        cnt_e  = n;
        for (int v = 0; v < n; v++) begin
            if (!sat_e && ((tbl_a[v] ^ tbl_b[v]) & mask) != 4'h0) begin
                sat_e  = 1'b1;
                cex_e  = v;
                diff_e = (tbl_a[v] ^ tbl_b[v]) & mask;
                cnt_e  = v + 1;
            end
        end
    endtask

    task automatic set_start(input int s, input logic val);
        if (s == 0) start0 = val;
        else        start1 = val;
    endtask

    task automatic set_abort(input int s, input logic val);
        if (s == 0) abort0 = val;
        else        abort1 = val;
    endtask

    // Start a sweep and follow it to done; poke pulses start mid-sweep.
    task automatic run_sweep(input int s, input bit poke);
        bit         sat_e;
        int         cex_e, cnt_e, cyc_e, per, nvec, j;
        logic [3:0] diff_e;
        bit         seq_ok;
        model(s, sat_e, cex_e, diff_e, cnt_e);
        per   = (s != 0) ? 2 : 3;
        nvec  = (s != 0) ? 8 : 4;
        cyc_e = cnt_e * per;
        sel   = s;
        @(negedge clk);
        set_start(s, 1'b1);
        @(posedge clk);
        #1;
        set_start(s, 1'b0);
        check_eq("busy_rise", 32'(v_busy), 32'd1);
        check_eq("done_clr", 32'(v_done), 32'd0);
        check_eq("sat_clr", 32'(v_sat), 32'd0);
        j      = 0;
        seq_ok = 1'b1;
        while (!v_done && j < 400) begin
            if (32'(v_stim) != 32'(j / per)) seq_ok = 1'b0;
            if (v_busy !== 1'b1) seq_ok = 1'b0;
            if (poke && j == 2) set_start(s, 1'b1);
            @(posedge clk);
            #1;
            set_start(s, 1'b0);
            j++;
        end
        check_eq("stim_seq", 32'(seq_ok), 32'd1);
        check_eq("done_latency", 32'(j), 32'(cyc_e));
        check_eq("busy_end", 32'(v_busy), 32'd0);
        check_eq("sat", 32'(v_sat), 32'(sat_e));
        check_eq("vec_cnt", 32'(v_cnt), 32'(cnt_e));
        check_eq("diff", 32'(v_diff), 32'(diff_e));
        check_eq("cex", 32'(v_cex), sat_e ? 32'(cex_e) : 32'd0);
        check_eq("stim_final", 32'(v_stim), sat_e ? 32'(cex_e) : 32'(nvec - 1));
        repeat (3) @(posedge clk);
        #1;
        check_eq("done_hold", 32'(v_done), 32'd1);
        check_eq("cnt_hold", 32'(v_cnt), 32'(cnt_e));
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_busy"}, 32'(v_busy), 32'd0);
        check_eq({tag, "_done"}, 32'(v_done), 32'd0);
        check_eq({tag, "_sat"}, 32'(v_sat), 32'd0);
        check_eq({tag, "_stim"}, 32'(v_stim), 32'd0);
        check_eq({tag, "_cex"}, 32'(v_cex), 32'd0);
        check_eq({tag, "_diff"}, 32'(v_diff), 32'd0);
        check_eq({tag, "_cnt"}, 32'(v_cnt), 32'd0);
    endtask

    // Circuit selector: 0 nand, 1 ~a|b, 2 or; a=stim[1], b=stim[0].
    task automatic load_fn(input int fa, input int fb);
        logic [2:0] v;
        logic       a, b;
        logic [3:0] r [2];
        int         f [2];
        f[0] = fa;
        f[1] = fb;
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            a = v[1];
            b = v[0];
            for (int k = 0; k < 2; k++) begin
                case (f[k])
                    0:       r[k] = {3'b000, ~(a & b)};
                    1:       r[k] = {3'b000, ~a | b};
                    default: r[k] = {3'b000, a | b};
                endcase
            end
            tbl_a[i] = r[0];
            tbl_b[i] = r[1];
        end
    endtask

    task automatic load_random(input int s);
        int p;
        for (int i = 0; i < 8; i++) begin
            tbl_a[i] = 4'($urandom);
            tbl_b[i] = tbl_a[i];
        end
        if ($urandom_range(0, 3) != 0) begin
            p = (s != 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 3));
            tbl_b[p] = tbl_a[p] ^ ((s != 0) ? 4'($urandom_range(1, 15)) : 4'h1);
        end
    endtask

    initial begin
        int j;
        n_checks = 0;
        n_errors = 0;
        sel      = 0;
        start0   = 1'b0;
        abort0   = 1'b0;
        start1   = 1'b0;
        abort1   = 1'b0;
        load_fn(0, 0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        sel = 0;
        #1;
        check_zero("reset0");
        sel = 1;
        #1;
        check_zero("reset1");
        @(negedge clk);
        rst = 1'b0;

        // Equivalent, then mismatch at vector 2, then at vector 0.
        load_fn(0, 0);
        run_sweep(0, 1'b0);
        load_fn(0, 1);
        run_sweep(0, 1'b0);
        load_fn(0, 2);
        run_sweep(0, 1'b0);

        // Abort while stim=1 of a clean sweep, then re-sweep.
        load_fn(0, 0);
        sel = 0;
        @(negedge clk);
        start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check_eq("pre_abort_stim", 32'(v_stim), 32'd1);
        abort0 = 1'b1;
        @(posedge clk);
        #1;
        abort0 = 1'b0;
        check_zero("abort");
        run_sweep(0, 1'b0);

        // start together with abort from DONE: abort wins.
        start0 = 1'b1;
        abort0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        abort0 = 1'b0;
        check_zero("abort_start");

        // Asynchronous reset mid-WAIT, checked before any clock edge.
        @(negedge clk);
        start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_zero("async_rst");
        @(negedge clk);
        rst = 1'b0;

        // start while busy is ignored.
        run_sweep(0, 1'b1);

        // 3-input, SETTLE=0, equivalent; repeated from DONE.
        for (int i = 0; i < 8; i++) begin
            tbl_a[i] = 4'(i * 5 + 3);
            tbl_b[i] = tbl_a[i];
        end
        run_sweep(1, 1'b0);
        run_sweep(1, 1'b0);

        // Randomized tables on both instances.
        for (int it = 0; it < 24; it++) begin
            j = int'($urandom_range(0, 1));
            load_random(j);
            run_sweep(j, ($urandom_range(0, 3) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
